// File: rtl/beep_seq.sv
// beep_seq: turns hit/win/over event pulses into bursts of tones on the beep stage's active-low start line.
// Defining BEEP_SEQ_WDOG_EN adds a per-tone watchdog (tone_cnt / wdog_err).
module beep_seq #(
    parameter int GAP_CYC  = 1000,
    parameter int N_HIT    = 1,
    parameter int N_WIN    = 3,
    parameter int N_OVER   = 5,
    parameter int CW       = 4,
    parameter int WDOG_CYC = 4096
) (
    input  logic clk,
    input  logic rst_n,
    input  logic evt_hit,
    input  logic evt_win,
    input  logic evt_over,
    input  logic beep_done,
    output logic beep_go_n,
    output logic busy,
    output logic evt_drop,
    output logic wdog_err
);
    localparam int GW = $clog2(GAP_CYC + 1);
    localparam logic [1:0] P_NONE = 2'd0;
    localparam logic [1:0] P_HIT  = 2'd1;
    localparam logic [1:0] P_WIN  = 2'd2;
    localparam logic [1:0] P_OVER = 2'd3;

    typedef enum logic [1:0] {S_IDLE, S_TONE, S_GAP} state_t;

    state_t        r_state;
    logic          r_go_n;
    logic          r_pend_vld;
    logic [1:0]    r_pend_prio;
    logic [CW-1:0] r_rem;
    logic [GW-1:0] r_gap_cnt;
    logic [1:0]    w_sel;
    logic [1:0]    w_nevt;
    logic          w_drop;

`ifdef BEEP_SEQ_WDOG_EN
    localparam int TW = $clog2(WDOG_CYC + 1);
    logic [TW-1:0] r_tone_cnt;
    logic          r_wdog;
`endif

    // Tones still to play after the first one, per event class.
    function automatic logic [CW-1:0] rem_of(input logic [1:0] prio);
        case (prio)
            P_OVER:  rem_of = CW'(N_OVER - 1);
            P_WIN:   rem_of = CW'(N_WIN - 1);
            default: rem_of = CW'(N_HIT - 1);
        endcase
    endfunction

    always_comb begin
        w_sel = P_NONE;
        if (evt_over)     w_sel = P_OVER;
        else if (evt_win) w_sel = P_WIN;
        else if (evt_hit) w_sel = P_HIT;
        w_nevt = {1'b0, evt_hit} + {1'b0, evt_win} + {1'b0, evt_over};
        // Outside IDLE a full slot always loses one event: the stored one or the new one.
        w_drop = (w_nevt > 2'd1) ||
                 ((r_state != S_IDLE) && r_pend_vld && (w_sel != P_NONE));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_go_n      <= 1'b1;
            r_pend_vld  <= 1'b0;
            r_pend_prio <= P_NONE;
            r_rem       <= '0;
            r_gap_cnt   <= '0;
`ifdef BEEP_SEQ_WDOG_EN
            r_tone_cnt  <= '0;
            r_wdog      <= 1'b0;
`endif
        end else begin
`ifdef BEEP_SEQ_WDOG_EN
            r_wdog <= 1'b0;
            if (r_state != S_TONE) r_tone_cnt <= '0;
`endif
            if ((r_state != S_IDLE) && (w_sel != P_NONE) &&
                (!r_pend_vld || (w_sel > r_pend_prio))) begin
                r_pend_vld  <= 1'b1;
                r_pend_prio <= w_sel;
            end

            case (r_state)
                S_IDLE: begin
                    if (r_pend_vld) begin
                        r_rem       <= rem_of(r_pend_prio);
                        r_pend_vld  <= (w_sel != P_NONE);
                        r_pend_prio <= w_sel;
                        r_state     <= S_TONE;
                        r_go_n      <= 1'b0;
                    end else if (w_sel != P_NONE) begin
                        r_rem   <= rem_of(w_sel);
                        r_state <= S_TONE;
                        r_go_n  <= 1'b0;
                    end
                end
                S_TONE: begin
                    if (beep_done) begin
                        r_go_n    <= 1'b1;
                        r_gap_cnt <= '0;
                        r_state   <= S_GAP;
`ifdef BEEP_SEQ_WDOG_EN
                    end else if (r_tone_cnt == TW'(WDOG_CYC - 1)) begin
                        r_wdog    <= 1'b1;
                        r_rem     <= '0;
                        r_go_n    <= 1'b1;
                        r_gap_cnt <= '0;
                        r_state   <= S_GAP;
                    end else begin
                        r_tone_cnt <= r_tone_cnt + TW'(1);
`endif
                    end
                end
                S_GAP: begin
                    if (r_gap_cnt == GW'(GAP_CYC - 1)) begin
                        if (r_rem != '0) begin
                            r_rem   <= r_rem - CW'(1);
                            r_go_n  <= 1'b0;
                            r_state <= S_TONE;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_gap_cnt <= r_gap_cnt + GW'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_go_n  <= 1'b1;
                end
            endcase
        end
    end

    assign beep_go_n = r_go_n;
    assign busy      = (r_state != S_IDLE) || r_pend_vld;
    assign evt_drop  = w_drop;
`ifdef BEEP_SEQ_WDOG_EN
    assign wdog_err  = r_wdog;
`else
    assign wdog_err  = (WDOG_CYC < 0);
`endif

endmodule

// File: tb/tb_beep_seq.sv
// Bench for beep_seq: directed bursts plus random events, checked against a timeline model of the sequencer.
module tb_beep_seq;
    localparam int GAP_CYC  = 1000;
    localparam int N_HIT    = 1;
    localparam int N_WIN    = 3;
    localparam int N_OVER   = 5;
    localparam int CW       = 4;
    localparam int WDOG_CYC = 4096;
`ifdef BEEP_SEQ_WDOG_EN
    localparam bit WDOG_ON = 1'b1;
`else
    localparam bit WDOG_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic evt_hit = 1'b0, evt_win = 1'b0, evt_over = 1'b0, beep_done = 1'b0;
    logic beep_go_n, busy, evt_drop, wdog_err;

    beep_seq #(
        .GAP_CYC(GAP_CYC), .N_HIT(N_HIT), .N_WIN(N_WIN), .N_OVER(N_OVER),
        .CW(CW), .WDOG_CYC(WDOG_CYC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .evt_hit(evt_hit), .evt_win(evt_win),
        .evt_over(evt_over), .beep_done(beep_done), .beep_go_n(beep_go_n),
        .busy(busy), .evt_drop(evt_drop), .wdog_err(wdog_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Timeline model: tone running, high cycles left in the gap, tones left after this one, pending class.
    bit m_go, m_wdog;
    int m_gap_left, m_todo, m_pend, m_age;

    function automatic int nbeeps(input int p);
        return (p == 3) ? N_OVER : ((p == 2) ? N_WIN : N_HIT);
    endfunction

    function automatic void start_seq(input int p);
        m_go   = 1'b1;
        m_todo = nbeeps(p) - 1;
        m_age  = 0;
    endfunction

    function automatic void model_reset();
        m_go = 1'b0; m_wdog = 1'b0; m_gap_left = 0; m_todo = 0; m_pend = 0; m_age = 0;
    endfunction

    // Beep stage emulation and observed go_n history.
    int  st_age = 0, st_dly = 10, st_lag_left = 0, dly_lo = 5, dly_hi = 30;
    bit  st_hang = 1'b0;
    bit  prev_go = 1'b1;
    int  n_low_win = 0, hi_run = 0, lo_run = 0, last_lo = 0, n_wdog = 0;
    int  gaps[$];
    logic last_drop;

    function automatic void clear_hist();
        n_low_win = 0; n_wdog = 0; gaps.delete();
    endfunction

    task automatic step(input logic h, input logic w, input logic o);
        int sel, nev;
        bit idle;
        @(negedge clk);
        evt_hit = h; evt_win = w; evt_over = o;
        if (!beep_go_n) begin
            st_age++;
            beep_done   = !st_hang && (st_age > st_dly);
            st_lag_left = $urandom_range(0, 3);
        end else begin
            if (st_lag_left > 0) st_lag_left--;
            else beep_done = 1'b0;
            st_age = 0;
            st_dly = $urandom_range(dly_lo, dly_hi);
        end
        #1;
        if (!beep_go_n) begin
            if (prev_go) begin
                n_low_win++;
                if (n_low_win > 1) gaps.push_back(hi_run);
            end
            hi_run = 0;
            lo_run++;
        end else begin
            if (!prev_go) last_lo = lo_run;
            lo_run = 0;
            hi_run++;
        end
        prev_go = beep_go_n;

        sel  = o ? 3 : (w ? 2 : (h ? 1 : 0));
        nev  = int'(h) + int'(w) + int'(o);
        idle = !m_go && (m_gap_left == 0);
        check("go_n", beep_go_n, !m_go);
        check("busy", busy, !idle || (m_pend != 0));
        check("evt_drop", evt_drop, (nev > 1) || (!idle && (m_pend != 0) && (sel != 0)));
        check("wdog_err", wdog_err, m_wdog);
        last_drop = evt_drop;
        if (wdog_err === 1'b1) n_wdog++;

        m_wdog = 1'b0;
        if (idle) begin
            if (m_pend != 0) begin
                start_seq(m_pend);
                m_pend = sel;
            end else if (sel != 0) begin
                start_seq(sel);
            end
        end else begin
            if (sel > m_pend) m_pend = sel;
            if (m_go) begin
                if (beep_done) begin
                    m_go = 1'b0; m_gap_left = GAP_CYC;
                end else if (WDOG_ON && (m_age == WDOG_CYC - 1)) begin
                    m_go = 1'b0; m_gap_left = GAP_CYC; m_todo = 0; m_wdog = 1'b1;
                end else begin
                    m_age++;
                end
            end else begin
                m_gap_left--;
                if ((m_gap_left == 0) && (m_todo > 0)) begin
                    m_todo--; m_go = 1'b1; m_age = 0;
                end
            end
        end
    endtask

    task automatic run_idle(input int bound, input string tag);
        int i;
        for (i = 0; i < bound; i++) begin
            step(1'b0, 1'b0, 1'b0);
            if (!m_go && (m_gap_left == 0) && (m_pend == 0)) break;
        end
        check({tag, "_finished"}, i < bound, 1'b1);
        repeat (3) step(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int exp5[7];
        exp5 = '{1000, 1000, 1001, 1000, 1000, 1000, 1000};
        model_reset();

        repeat (3) @(negedge clk);
        check("rst_go_n", beep_go_n, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_drop", evt_drop, 1'b0);
        check("rst_wdog", wdog_err, 1'b0);
        rst_n = 1'b1;
        repeat (5) step(1'b0, 1'b0, 1'b0);

        // Single hit, done about 1000 cycles into the tone.
        dly_lo = 1000; dly_hi = 1000;
        repeat (2) step(1'b0, 1'b0, 1'b0);
        clear_hist();
        step(1'b1, 1'b0, 1'b0);
        run_idle(4000, "hit");
        check("hit_windows", n_low_win, 1);

        // Win burst: three tones, exact gaps.
        dly_lo = 5; dly_hi = 30;
        clear_hist();
        step(1'b0, 1'b1, 1'b0);
        run_idle(5000, "win");
        check("win_windows", n_low_win, 3);
        check("win_gap_count", gaps.size(), 2);
        foreach (gaps[k]) check("win_gap_len", gaps[k], GAP_CYC);
        check("win_busy_end", busy, 1'b0);

        // Simultaneous hit and over.
        clear_hist();
        step(1'b1, 1'b0, 1'b1);
        check("hit_over_drop", last_drop, 1'b1);
        run_idle(8000, "hit_over");
        check("hit_over_windows", n_low_win, 5);

        // Events during a win burst: hit parks in the slot, over replaces it.
        clear_hist();
        step(1'b0, 1'b1, 1'b0);
        repeat (50) step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        check("pend_hit_drop", last_drop, 1'b0);
        repeat (30) step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        check("pend_over_drop", last_drop, 1'b1);
        run_idle(12000, "win_then_over");
        check("win_over_windows", n_low_win, 8);
        check("win_over_gap_count", gaps.size(), 7);
        for (int k = 0; k < gaps.size() && k < 7; k++) check("win_over_gap_len", gaps[k], exp5[k]);

        // Asynchronous reset in the middle of a tone.
        dly_lo = 200; dly_hi = 300;
        clear_hist();
        step(1'b0, 1'b1, 1'b0);
        repeat (50) step(1'b0, 1'b0, 1'b0);
        check("pre_rst_go_n", beep_go_n, 1'b0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async_go_n", beep_go_n, 1'b1);
        check("rst_async_busy", busy, 1'b0);
        model_reset();
        beep_done = 1'b0; st_lag_left = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2000) step(1'b0, 1'b0, 1'b0);
        check("rst_no_resume", n_low_win, 1);

        // Stage that never reports done.
        dly_lo = 5; dly_hi = 30;
        clear_hist();
        st_hang = 1'b1;
`ifdef BEEP_SEQ_WDOG_EN
        step(1'b0, 1'b1, 1'b0);
        run_idle(8000, "wdog");
        st_hang = 1'b0;
        check("wdog_pulses", n_wdog, 1);
        check("wdog_tone_len", last_lo, WDOG_CYC);
        check("wdog_windows", n_low_win, 1);
`else
        step(1'b1, 1'b0, 1'b0);
        repeat (6000) step(1'b0, 1'b0, 1'b0);
        check("hang_go_n", beep_go_n, 1'b0);
        st_hang = 1'b0;
        run_idle(3000, "hang_release");
        check("hang_wdog", n_wdog, 0);
        check("hang_windows", n_low_win, 1);
`endif

        // Random events against the model.
        dly_lo = 1; dly_hi = 60;
        for (int c = 0; c < 20000; c++) begin
            step($urandom_range(0, 999) < 4, $urandom_range(0, 999) < 3,
                 $urandom_range(0, 999) < 2);
        end
        run_idle(15000, "random");
        check("random_busy_end", busy, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
